store_align_buffer: RTL and testbench
=====================================

// Module: store_align_buffer
// PURPOSE
//  Store-side counterpart of the load-data extractor: turns sb/sh/sw requests from the MEM stage
//  into word-aligned writes with byte enables and lane-replicated data.
//  Buffers up to DEPTH stores and drains them in order to the data-memory / bridge write port.
//  Flags misaligned stores (AdES) and reports word-address hits so the hazard unit can stall loads.
// PARAMETERS
//  DEPTH   2  number of buffered stores; power of two, >= 2
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  st_valid   in   1   store request from MEM stage
//  st_ready   out  1   buffer can accept; = (count < DEPTH)
//  st_size    in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  st_addr    in   32  byte address
//  st_data    in   32  rt value; low byte/half used for sb/sh
//  st_exc     out  1   registered one-cycle pulse: previous accepted request was misaligned/illegal
//  exc_addr   out  32  BadVAddr of the last faulting request; held until next fault
//  mem_valid  out  1   head entry presented to memory
//  mem_ready  in   1   memory accepts head entry this cycle
//  mem_addr   out  32  head word address, bits [1:0] = 00
//  mem_wdata  out  32  head lane-replicated data
//  mem_be     out  4   head byte enables, bit i = byte lane i (bits 8i+7:8i)
//  ld_addr    in   32  address of the load currently in MEM
//  ld_hit     out  1   combinational: any valid entry has word address == ld_addr[31:2]
//  empty      out  1   count == 0; used to drain before syscall/eret/mtc0
// BEHAVIOUR
//  Handshake: request taken when st_valid && st_ready. No same-cycle bypass: a store taken at edge N
//   appears on mem_* after edge N at the earliest.
//  Encoding (a = st_addr[1:0]):
//   byte: be = 4'b0001 << a; wdata = {4{st_data[7:0]}}
//   half: legal only if a[0] == 0; be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}
//   word: legal only if a == 00; be = 4'b1111; wdata = st_data
//   size 11 or misaligned: faulting.
//  mem_addr = {st_addr[31:2], 2'b00}.
//  Faulting request: still consumes the handshake but is NOT enqueued; count unchanged.
//   st_exc = 1 for exactly the next cycle; exc_addr <= st_addr (full byte address).
//  FIFO: write/read pointers wrap modulo DEPTH; count in 0..DEPTH.
//   mem_valid = (count != 0); mem_addr/mem_wdata/mem_be show the head entry.
//   These stay stable while mem_valid && !mem_ready.
//   Dequeue happens on mem_valid && mem_ready.
//  Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
//   At count == DEPTH, st_ready = 0, so no enqueue even when a dequeue occurs that cycle.
//  Order is strictly FIFO; no merging or coalescing of entries.
//  ld_hit compares only valid entries and ignores be; ld_hit = 0 when empty.
//  Reset (asynchronous, any time, including mid-drain): pointers/count = 0, mem_valid = 0,
//   st_exc = 0, exc_addr = 0, storage = 0 so mem_addr/mem_wdata/mem_be read 0.
//   Pending stores are discarded. st_ready = 1 and empty = 1 during and after reset.
// TESTING
//  1. sb addr 0x00001003 data 0x000000AB, mem_ready=1
//     -> next cycle mem_addr 0x00001000, be 1000, wdata 0xABABABAB; then empty=1.
//  2. sh addr 0x00002002 data 0xFFFF1234 -> be 1100, wdata 0x12341234.
//     sh at 0x00002000 -> be 0011.
//  3. sw addr 0x00003002 -> nothing enqueued, st_exc=1 for one cycle, exc_addr 0x00003002,
//     empty stays 1. size=11 at 0x4000 -> same fault response.
//  4. mem_ready=0, three back-to-back sw (0x10, 0x20, 0x30)
//     -> st_ready low after the 2nd; third waits.
//     Release mem_ready -> writes appear in order 0x10, 0x20, 0x30 with stable outputs while stalled.
//  5. count=1 with mem_ready=1 and st_valid=1 in the same cycle -> count stays 1; new entry becomes head.
//     ld_addr 0x00000022 with an entry at 0x20 -> ld_hit=1.
//  6. reset_n low asynchronously while 2 entries are pending
//     -> mem_valid drops immediately, empty=1, st_exc=0; after release the next store drains normally.

Source files
------------

// File: rtl/store_align_buffer_if.sv
// Bus bundle for the store alignment buffer: MEM-stage store request, memory write port,
// load-hazard probe and fault reporting.
interface store_align_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_exc;
    logic [31:0] exc_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        empty;

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ready, ld_addr,
        input  st_ready, st_exc, exc_addr, mem_valid, mem_addr, mem_wdata, mem_be, ld_hit, empty
    );

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ready, ld_addr,
        output st_ready, st_exc, exc_addr, mem_valid, mem_addr, mem_wdata, mem_be, ld_hit, empty
    );
endinterface

// File: rtl/store_align_buffer.sv
// Store alignment buffer: encodes sb/sh/sw into word writes with byte enables, queues them
// in a small FIFO, drains in order to memory and flags misaligned/illegal stores.
module store_align_buffer #(
    parameter int DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    store_align_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef logic [PW-1:0] ptr_t;

    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [CW-1:0] count;
    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic          illegal;
    logic [3:0]    enc_be;
    logic [31:0]   enc_data;
    logic          accept;
    logic          enq;
    logic          deq;
    logic          hit;
    logic          exc_q;
    logic [31:0]   exc_addr_q;
    logic          unused_ld_low;

    always_comb begin
        illegal  = 1'b0;
        enc_be   = 4'b0000;
        enc_data = bus.st_data;
        case (bus.st_size)
            2'b00: begin
                enc_be   = 4'b0001 << bus.st_addr[1:0];
                enc_data = {4{bus.st_data[7:0]}};
            end
            2'b01: begin
                illegal  = bus.st_addr[0];
                enc_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                enc_data = {2{bus.st_data[15:0]}};
            end
            2'b10: begin
                illegal  = |bus.st_addr[1:0];
                enc_be   = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign bus.st_ready  = (count < CW'(DEPTH));
    assign accept        = bus.st_valid && bus.st_ready;
    assign enq           = accept && !illegal;
    assign deq           = bus.mem_valid && bus.mem_ready;
    assign bus.mem_valid = (count != '0);
    assign bus.empty     = (count == '0);
    assign bus.mem_addr  = {addr_mem[rd_ptr], 2'b00};
    assign bus.mem_wdata = data_mem[rd_ptr];
    assign bus.mem_be    = be_mem[rd_ptr];
    assign bus.st_exc    = exc_q;
    assign bus.exc_addr  = exc_addr_q;
    assign bus.ld_hit    = hit;
    assign unused_ld_low = ^bus.ld_addr[1:0];

    // A slot is live when its distance from the head is below count (pointer wrap is modulo DEPTH).
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, ptr_t'(ptr_t'(i) - rd_ptr)} < count) &&
                (addr_mem[i] == bus.ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_t'(1);
            if (deq) rd_ptr <= rd_ptr + ptr_t'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                be_mem[i]   <= '0;
            end
        end else if (enq) begin
            addr_mem[wr_ptr] <= bus.st_addr[31:2];
            data_mem[wr_ptr] <= enc_data;
            be_mem[wr_ptr]   <= enc_be;
        end
    end

    // Faulting requests complete the handshake but never enter the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            exc_q <= accept && illegal;
            if (accept && illegal) exc_addr_q <= bus.st_addr;
        end
    end
endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer: directed scenarios plus random traffic, with a queue-based
// reference model and a negedge monitor that scores every presented write and status flag.
module tb_store_align_buffer;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n;

    store_align_buffer_if bus ();

    store_align_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exc_q[$];
    logic [31:0] exp_exc_addr = '0;
    int          checks   = 0;
    int          failures = 0;
    logic        stall_seen = 1'b0;
    wr_t         held;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    // Lane view of a store: n bytes starting at lane a; every lane carries byte (lane mod n).
    function automatic logic model_store(input logic [1:0] size, input logic [31:0] addr,
                                         input logic [31:0] data, output wr_t w);
        int n;
        int a;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a = int'(addr[1:0]);
        w.addr  = {addr[31:2], 2'b00};
        w.be    = '0;
        w.wdata = '0;
        if (size == 2'd3 || (a % n) != 0) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i >= a && i < a + n) w.be[i] = 1'b1;
            w.wdata[8*i +: 8] = data[8*(i % n) +: 8];
        end
        return 1'b1;
    endfunction

    function automatic logic model_hit(input logic [31:0] la);
        foreach (exp_q[i]) if (exp_q[i].addr[31:2] == la[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: outputs are stable at the falling edge; a write with mem_ready set here transfers
    // at the next rising edge.
    always @(negedge clk) begin
        check("empty", bus.empty, exp_q.size() == 0);
        check("st_ready", bus.st_ready, exp_q.size() < DEPTH);
        check("mem_valid", bus.mem_valid, exp_q.size() != 0);
        check("ld_hit", bus.ld_hit, model_hit(bus.ld_addr));
        if (exc_q.size() > 0) begin
            check("st_exc_pulse", bus.st_exc, 1'b1);
            exp_exc_addr = exc_q.pop_front();
        end else begin
            check("st_exc_idle", bus.st_exc, 1'b0);
        end
        check("exc_addr", bus.exc_addr, exp_exc_addr);
        if (stall_seen && bus.mem_valid) begin
            check("stall_addr", bus.mem_addr, held.addr);
            check("stall_wdata", bus.mem_wdata, held.wdata);
            check("stall_be", bus.mem_be, held.be);
        end
        if (bus.mem_valid && exp_q.size() > 0) begin
            check("mem_addr", bus.mem_addr, exp_q[0].addr);
            check("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
            check("mem_be", bus.mem_be, exp_q[0].be);
            if (bus.mem_ready) begin
                void'(exp_q.pop_front());
                stall_seen = 1'b0;
            end else begin
                stall_seen = 1'b1;
                held.addr  = bus.mem_addr;
                held.wdata = bus.mem_wdata;
                held.be    = bus.mem_be;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic cycle(input logic v, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic mr, input logic [31:0] la,
                         output logic taken);
        logic rdy;
        wr_t  w;
        bus.st_valid  = v;
        bus.st_size   = sz;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.mem_ready = mr;
        bus.ld_addr   = la;
        @(negedge clk);
        rdy = bus.st_ready;
        @(posedge clk);
        #1;
        taken = v && rdy;
        if (taken) begin
            if (model_store(sz, a, d, w)) exp_q.push_back(w);
            else exc_q.push_back(a);
        end
    endtask

    task automatic idle(input int n, input logic mr, input logic [31:0] la);
        logic t;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'h0, 32'h0, mr, la, t);
    endtask

    task automatic apply_reset();
        bus.st_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        exc_q.delete();
        exp_exc_addr = '0;
        stall_seen   = 1'b0;
        #1;
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_st_ready", bus.st_ready, 1'b1);
        check("rst_st_exc", bus.st_exc, 1'b0);
        check("rst_exc_addr", bus.exc_addr, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_be", bus.mem_be, 4'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        t;
        logic [31:0] a;
        logic [1:0]  sz;
        reset_n       = 1'b1;
        bus.st_valid  = 1'b0;
        bus.st_size   = 2'd0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.mem_ready = 1'b0;
        bus.ld_addr   = '0;
        #1;
        apply_reset();

        // sb to lane 3, then drain
        cycle(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB, 1'b1, 32'h0000_1000, t);
        idle(3, 1'b1, 32'h0000_1000);

        // sh upper and lower half
        cycle(1'b1, 2'd1, 32'h0000_2002, 32'hFFFF_1234, 1'b1, 32'h0, t);
        cycle(1'b1, 2'd1, 32'h0000_2000, 32'hFFFF_1234, 1'b1, 32'h0, t);
        idle(3, 1'b1, 32'h0);

        // misaligned word and illegal size
        cycle(1'b1, 2'd2, 32'h0000_3002, 32'h1111_2222, 1'b1, 32'h0, t);
        idle(2, 1'b1, 32'h0);
        cycle(1'b1, 2'd3, 32'h0000_4000, 32'h3333_4444, 1'b1, 32'h0, t);
        idle(2, 1'b1, 32'h0);

        // back-pressure: third store waits until memory releases
        cycle(1'b1, 2'd2, 32'h0000_0010, 32'hA0A0_0010, 1'b0, 32'h0000_0022, t);
        cycle(1'b1, 2'd2, 32'h0000_0020, 32'hA0A0_0020, 1'b0, 32'h0000_0022, t);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'd2, 32'h0000_0030, 32'hA0A0_0030, 1'b0, 32'h0000_0022, t);
            check("third_waits", t, 1'b0);
        end
        t = 1'b0;
        for (int i = 0; i < 20 && !t; i++)
            cycle(1'b1, 2'd2, 32'h0000_0030, 32'hA0A0_0030, 1'b1, 32'h0000_0022, t);
        check("third_taken", t, 1'b1);
        idle(4, 1'b1, 32'h0000_0022);

        // simultaneous enqueue and dequeue at count 1
        cycle(1'b1, 2'd2, 32'h0000_0040, 32'hB0B0_0040, 1'b0, 32'h0000_0042, t);
        cycle(1'b1, 2'd2, 32'h0000_0050, 32'hB0B0_0050, 1'b1, 32'h0000_0052, t);
        check("simul_taken", t, 1'b1);
        idle(3, 1'b1, 32'h0000_0052);

        // reset while two stores are pending, then normal operation
        cycle(1'b1, 2'd0, 32'h0000_0061, 32'h0000_00C1, 1'b0, 32'h0, t);
        cycle(1'b1, 2'd1, 32'h0000_0072, 32'h0000_C2C2, 1'b0, 32'h0, t);
        apply_reset();
        cycle(1'b1, 2'd2, 32'h0000_0080, 32'hDEAD_BEEF, 1'b1, 32'h0000_0080, t);
        idle(3, 1'b1, 32'h0);

        // random traffic over a small address window so hazards and back-pressure occur
        for (int i = 0; i < 1500; i++) begin
            a  = 32'h0000_0100 + 32'($urandom_range(0, 15));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            cycle($urandom_range(0, 3) != 0, sz, a, $urandom,
                  $urandom_range(0, 2) != 0, 32'h0000_0100 + 32'($urandom_range(0, 15)), t);
        end
        idle(6, 1'b1, 32'h0);
        check("drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
